eth_frame_serializer: RTL
=========================

ETH_FRAME_SERIALIZER -- requirements
Module: eth_frame_serializer

Interface
REQ-001 SHALL have parameter LANES, default 1, output bits per clock; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 7, count of 0x55 preamble bytes, range 1..15.
REQ-003 SHALL have parameter IFG_LEN, default 12, inter-frame gap in bytes, range 1..255.
REQ-004 SHALL have parameter MIN_LEN, default 60, minimum payload bytes before FCS; 0 disables padding.
REQ-005 SHALL have parameter FCS_EN, default 1, appends CRC-32 when 1.
REQ-006 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port in_data  in  8  payload byte.
REQ-009 SHALL have port in_valid  in  1  in_data valid.
REQ-010 SHALL have port in_last  in  1  marks the final payload byte of a frame.
REQ-011 SHALL have port in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-012 SHALL have port tx_data  out  LANES  serial line data, bit 0 first in time.
REQ-013 SHALL have port tx_en  out  1  high while a frame occupies the line.
REQ-014 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse after the final frame slice.
REQ-016 SHALL have port underrun  out  1  one-cycle pulse on a mid-frame abort.

Function
REQ-017 SHALL implement FSM states IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG.
REQ-018 SHALL emit each byte as 8/LANES consecutive slices, LSB first; slice k carries byte bits [k*LANES +: LANES].
REQ-019 SHALL leave IDLE for PREAMBLE in the cycle after in_valid=1 is sampled in IDLE, without consuming the byte; tx_en rises with the first preamble slice.
REQ-020 SHALL send PREAMBLE_LEN bytes of 0x55, then one SFD byte of 0xD5.
REQ-021 SHALL hold in_ready=1 only during the last slice of SFD, PAYLOAD and non-final bytes; in all other cycles it SHALL be 0.
REQ-022 SHALL, on a byte handshake with in_last=0, serialise that byte next and remain in PAYLOAD.
REQ-023 SHALL, on a byte handshake with in_last=1, go next to PAD if byte count < MIN_LEN, else to FCS (FCS_EN=1), else to IFG.
REQ-024 SHALL, in PAD, send 0x00 bytes until byte count equals MIN_LEN.
REQ-025 SHALL count payload+pad bytes in a 16-bit counter that saturates at 0xFFFF and clears at frame start.
REQ-026 SHALL compute CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) over payload and pad bytes, and in FCS send the bitwise complement of the final CRC as 4 bytes, least significant byte first.
REQ-027 SHALL drive tx_en=0 and tx_data=0 throughout IFG, for IFG_LEN*8/LANES cycles, then return to IDLE.
REQ-028 SHALL pulse frame_done in the first IFG cycle of a normally completed frame.
REQ-029 SHALL treat in_valid=0 while in_ready=1 as underrun: pulse underrun, skip PAD/FCS, deassert tx_en in the next cycle, enter IFG, and not pulse frame_done.
REQ-030 SHALL ignore in_valid and in_last in every cycle where in_ready=0.
REQ-031 SHALL, when in_valid=1 in the final IFG cycle, start the next frame with no extra idle cycle (back-to-back frames separated by exactly IFG_LEN byte times).

Reset
REQ-032 SHALL, while reset_n=0, force state IDLE, in_ready/tx_en/busy/frame_done/underrun=0, tx_data=0, counters=0, CRC=0xFFFFFFFF.
REQ-033 SHALL abandon a frame in progress when reset_n is asserted; no frame_done or underrun pulse results.
REQ-034 SHALL begin operation on the first rising clock edge after reset_n deasserts.

Verification
REQ-035 SHALL pass: LANES=1, single frame -> first 64 tx_data bits are 28 repeats of 1,0 followed by 1,0,1,0,1,0,1,1 (SFD 0xD5).
REQ-036 SHALL pass: LANES=8, 64-byte frame, FCS_EN=1 -> tx_en high exactly 76 cycles, last 4 bytes equal software CRC-32 model, then 12 low cycles.
REQ-037 SHALL pass: LANES=8, 1-byte frame 0xA5 -> 0xA5 plus 59 bytes 0x00, then FCS over those 60 bytes; tx_en high 72 cycles.
REQ-038 SHALL pass: LANES=4, in_valid drops at byte 10 -> underrun pulses once, tx_en low next cycle, no frame_done, IFG of 24 cycles follows.
REQ-039 SHALL pass: two frames with in_valid held high -> second tx_en rise exactly IFG_LEN*8/LANES cycles after first tx_en fall.
REQ-040 SHALL pass: reset_n pulsed low mid-PAYLOAD -> all outputs 0 immediately; next frame starts with a full preamble.

Source files
------------

// File: rtl/eth_frame_serializer.sv
// eth_frame_serializer: turns a byte stream into a framed serial line.
// A frame is preamble, SFD, payload, zero pad up to MIN_LEN, and a CRC-32 FCS.
// The frame goes out LANES bits per clock, and a quiet inter-frame gap follows.
module eth_frame_serializer #(
   parameter int LANES        = 1,
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_LEN      = 12,
   parameter int MIN_LEN      = 60,
   parameter int FCS_EN       = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [LANES-1:0] tx_data,
   output logic             tx_en,
   output logic             busy,
   output logic             frame_done,
   output logic             underrun
);

   localparam int          SLICES   = 8 / LANES;
   localparam logic [2:0]  SL_LAST  = 3'(SLICES - 1);
   localparam logic [11:0] PRE_LAST = 12'(PREAMBLE_LEN - 1);
   localparam logic [11:0] IFG_LAST = 12'(IFG_LEN * SLICES - 1);
   localparam logic [15:0] MIN_L    = 16'(MIN_LEN);

   typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG} state_t;

   state_t      state_q, state_d;
   logic [7:0]  sh_q, sh_d;        // byte on the line; the low LANES bits are the current slice
   logic [2:0]  slice_q, slice_d;
   logic [11:0] cnt_q, cnt_d;      // preamble / FCS byte index, or IFG cycle count
   logic [15:0] len_q, len_d;      // payload + pad bytes, saturating
   logic [31:0] crc_q, crc_d;      // running CRC; reused as the FCS byte shifter in FCS
   logic        last_q, last_d;    // byte on the line is the final payload byte
   logic        in_ready_q, tx_en_q, busy_q, done_q, urun_q;
   logic        done_d, urun_d, tail, start;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // next-state: slice shifting, byte sequencing, handshakes and frame tail
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      slice_d = slice_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      crc_d   = crc_q;
      last_d  = last_q;
      done_d  = 1'b0;
      urun_d  = 1'b0;
      tail    = 1'b0;
      start   = 1'b0;
      case (state_q)
         IDLE: start = in_valid;
         IFG: begin
            if (cnt_q == IFG_LAST) begin
               state_d = IDLE;
               start   = in_valid;   // back-to-back: no idle cycle in between
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         default: begin
            if (slice_q != SL_LAST) begin
               sh_d    = 8'(sh_q >> LANES);
               slice_d = slice_q + 3'd1;
            end else begin
               slice_d = 3'd0;
               case (state_q)
                  PREAMBLE: begin
                     if (cnt_q == PRE_LAST) begin
                        state_d = SFD;
                        sh_d    = 8'hD5;
                        cnt_d   = 12'd0;
                     end else begin
                        sh_d  = 8'h55;
                        cnt_d = cnt_q + 12'd1;
                     end
                  end
                  FCS: begin
                     if (cnt_q == 12'd3) begin
                        state_d = IFG;
                        sh_d    = 8'h00;
                        cnt_d   = 12'd0;
                        done_d  = 1'b1;
                     end else begin
                        sh_d  = crc_q[7:0];
                        crc_d = {8'd0, crc_q[31:8]};
                        cnt_d = cnt_q + 12'd1;
                     end
                  end
                  PAD: tail = 1'b1;
                  default: begin   // SFD or PAYLOAD, last slice of the byte
                     if (state_q == PAYLOAD && last_q) begin
                        tail = 1'b1;
                     end else if (in_valid) begin
                        state_d = PAYLOAD;
                        sh_d    = in_data;
                        len_d   = sat_inc(len_q);
                        crc_d   = crc_byte(crc_q, in_data);
                        last_d  = in_last;
                     end else begin
                        // source starved the line: cut the frame short
                        state_d = IFG;
                        sh_d    = 8'h00;
                        cnt_d   = 12'd0;
                        urun_d  = 1'b1;
                     end
                  end
               endcase
            end
         end
      endcase
      if (tail) begin
         if (len_q < MIN_L) begin
            state_d = PAD;
            sh_d    = 8'h00;
            len_d   = sat_inc(len_q);
            crc_d   = crc_byte(crc_q, 8'h00);
         end else if (FCS_EN != 0) begin
            state_d = FCS;
            sh_d    = ~crc_q[7:0];
            crc_d   = {8'd0, ~crc_q[31:8]};
            cnt_d   = 12'd0;
         end else begin
            state_d = IFG;
            sh_d    = 8'h00;
            cnt_d   = 12'd0;
            done_d  = 1'b1;
         end
      end
      if (start) begin
         state_d = PREAMBLE;
         sh_d    = 8'h55;
         slice_d = 3'd0;
         cnt_d   = 12'd0;
         len_d   = 16'd0;
         crc_d   = 32'hFFFFFFFF;
         last_d  = 1'b0;
      end
   end

   // state and registered outputs, all derived from the next state
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         sh_q       <= 8'h00;
         slice_q    <= 3'd0;
         cnt_q      <= 12'd0;
         len_q      <= 16'd0;
         crc_q      <= 32'hFFFFFFFF;
         last_q     <= 1'b0;
         in_ready_q <= 1'b0;
         tx_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         urun_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         slice_q    <= slice_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         crc_q      <= crc_d;
         last_q     <= last_d;
         in_ready_q <= ((state_d == SFD) || (state_d == PAYLOAD && !last_d)) && (slice_d == SL_LAST);
         tx_en_q    <= (state_d != IDLE) && (state_d != IFG);
         busy_q     <= (state_d != IDLE);
         done_q     <= done_d;
         urun_q     <= urun_d;
      end
   end

   assign tx_data    = sh_q[LANES-1:0];
   assign in_ready   = in_ready_q;
   assign tx_en      = tx_en_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign underrun   = urun_q;

endmodule
